// File: rtl/demux_1_to_4_stream_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer and its 4-to-1 selector counterpart.
package demux_1_to_4_stream_pkg;

  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned CH_IDX_W = 2;

  typedef logic [CH_IDX_W-1:0] ch_idx_t;

  function automatic ch_idx_t sel_to_ch(input logic s1, input logic s0);
    return {s1, s0};
  endfunction

endpackage

// File: rtl/demux_1_to_4_stream_ch_slot.sv
// One output channel: single-entry holding register, valid flag and accepted-word counter.
module demux_ch_slot
  import demux_1_to_4_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic [CNT_W-1:0] cnt
);

  // A load on the same edge as a drain wins, keeping valid high for full throughput.
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      valid <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      q     <= data;
      valid <= 1'b1;
      cnt   <= cnt + 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1_to_4_stream.sv
// Registered 1-to-4 stream demultiplexer, routing by {s1,s0} or by an internal round-robin pointer.
module demux_1_to_4_stream
  import demux_1_to_4_stream_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned RR_MODE = 0,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      s0,
  input  logic                      s1,
  output logic [NUM_CH*WIDTH-1:0]   out_data,
  output logic [NUM_CH-1:0]         out_valid,
  input  logic [NUM_CH-1:0]         out_ready,
  output logic [NUM_CH*CNT_W-1:0]   cnt,
  output logic [CH_IDX_W-1:0]       rr_ptr
);

  ch_idx_t target;
  ch_idx_t rr_q;
  logic    accept;

  always_comb begin
    target = sel_to_ch(s1, s0);
    if (RR_MODE != 0) target = rr_q;
  end

  assign in_ready = ~out_valid[target] | out_ready[target];
  assign accept   = in_valid & in_ready;
  assign rr_ptr   = rr_q;

  // Pointer only moves on an accept, so a blocked channel stalls the stream rather than being skipped.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= '0;
    end else if ((RR_MODE != 0) && accept) begin
      rr_q <= rr_q + ch_idx_t'(1);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    demux_ch_slot #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
    ) u_slot (
      .clk  (clk),
      .rst  (rst),
      .load (accept && (target == ch_idx_t'(k))),
      .drain(out_ready[k]),
      .data (in_data),
      .q    (out_data[k*WIDTH +: WIDTH]),
      .valid(out_valid[k]),
      .cnt  (cnt[k*CNT_W +: CNT_W])
    );
  end

endmodule
